// File: rtl/fetch_unit_if.sv
// Bus bundle between the RV32I fetch stage, instruction memory and the core controller.
// The master modport is the fetch unit; the slave modport is the memory/core side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  funct7;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7, fetch_fault,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7, fetch_fault,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register plus a one-outstanding req/gnt/rvalid fetch FSM.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects in a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3
  } state_t;
`endif

  state_t      state_r;
  state_t      state_n;
  logic [31:0] pc_r;
  logic [31:0] pc_n;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic        capture_s;
  logic        req_r;
  logic        valid_r;
  logic        fault_r;

  // Next-state, next-PC and capture-enable decode
  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_gnt) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          state_n   = S_VALID;
          capture_s = 1'b1;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_VALID: begin
        if (bus.instr_ready) begin
          if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            // A misaligned target parks the stage; pc keeps the faulting instruction's address.
            if (bus.redirect_pc[1:0] != 2'b00) begin
              state_n = S_FAULT;
              pc_n    = pc_r;
            end else begin
              state_n = S_REQ;
              pc_n    = bus.redirect_pc;
            end
`else
            state_n = S_REQ;
            pc_n    = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
          end else begin
            state_n = S_REQ;
            pc_n    = pc_r + 32'd4;
          end
        end else begin
          state_n = S_VALID;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_FAULT: begin
        state_n = S_FAULT;
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, PC and registered handshake outputs (decoded from the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      pc_r    <= BOOT_PC;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      req_r   <= (state_n == S_REQ);
      valid_r <= (state_n == S_VALID);
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_r <= (state_n == S_FAULT);
`else
      fault_r <= 1'b0;
`endif
    end
  end

  // Instruction word and its address, captured on the read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= NOP;
      instr_pc_r <= BOOT_PC;
    end else if (capture_s) begin
      instr_r    <= bus.imem_rdata;
      instr_pc_r <= pc_r;
    end else begin
      instr_r    <= instr_r;
      instr_pc_r <= instr_pc_r;
    end
  end

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.opcode      = instr_r[6:0];
  assign bus.funct3      = instr_r[14:12];
  assign bus.funct7      = {instr_r[30], instr_r[25]};
  assign bus.fetch_fault = fault_r;

endmodule
